// File: rtl/spi_txn_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_arb_pkg
//  Description : Shared types and constants for the SPI transaction arbiter:
//                sequencer state encoding, spi_core slot register addresses
//                and the ready-bit position in the slot read data.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        SEL   = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        POLL  = 3'd5,
        DESEL = 3'd6,
        DONE  = 3'd7
    } state_t;

    // spi_core slot register map
    localparam logic [4:0] SPI_ADDR_STAT = 5'd0;
    localparam logic [4:0] SPI_ADDR_SS   = 5'd1;
    localparam logic [4:0] SPI_ADDR_DATA = 5'd2;
    localparam logic [4:0] SPI_ADDR_CTRL = 5'd3;

    localparam int SPI_READY_BIT = 8;

endpackage
`default_nettype wire

// File: rtl/spi_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_arbiter_if
//  Description : Requester-side and spi_core slot-side signals of the SPI
//                transaction arbiter.
//                master : arbiter view (samples requests, drives the slot bus)
//                slave  : environment view (requesters + spi_core)
//  Ports       : req/req_len/req_ss/req_tx/req_cfg  - per-requester request
//                grant/done/rx_data                 - per-requester response
//                m_cs/m_read/m_write/m_addr/m_wr_data/m_rd_data - slot bus
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_txn_arbiter_if #(
    parameter int N  = 2,
    parameter int S  = 2,
    parameter int SW = (S > 1) ? $clog2(S) : 1
);
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_len;
    logic [SW*N-1:0] req_ss;
    logic [32*N-1:0] req_tx;
    logic [18*N-1:0] req_cfg;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [31:0]     rx_data;

    logic            m_cs;
    logic            m_read;
    logic            m_write;
    logic [4:0]      m_addr;
    logic [31:0]     m_wr_data;
    logic [31:0]     m_rd_data;

    modport master (
        input  req, req_len, req_ss, req_tx, req_cfg, m_rd_data,
        output grant, done, rx_data, m_cs, m_read, m_write, m_addr, m_wr_data
    );

    modport slave (
        output req, req_len, req_ss, req_tx, req_cfg, m_rd_data,
        input  grant, done, rx_data, m_cs, m_read, m_write, m_addr, m_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : N-way round-robin picker. Selects the first request at or
//                after the pointer (wrapping); the pointer moves to
//                winner+1 mod N when i_advance is asserted.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                i_req                 - request vector
//                i_advance             - current pick was granted
//                o_grant/o_idx/o_valid - one-hot pick, its index, any request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [N-1:0]  i_req,
    input  wire logic          i_advance,
    output logic      [N-1:0]  o_grant,
    output logic      [PW-1:0] o_idx,
    output logic               o_valid
);

    logic [PW-1:0] r_ptr;
    logic [PW:0]   w_sum;
    logic [PW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(N)) begin
                w_sum = w_sum - (PW+1)'(N);
            end
            w_cand = w_sum[PW-1:0];
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_idx == PW'(N - 1)) ? '0 : o_idx + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_arbiter
//  Description : Shares one spi_core slot among N requesters. Each granted
//                request runs: ctrl write, slave-select write, then per byte
//                start / one idle cycle / ready poll with capture, and finally
//                a deselect write and a one-cycle done pulse.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus        - spi_txn_arbiter_if.master (requests, grant,
//                             done, rx_data and the spi_core slot bus)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int S  = 2,
    parameter int SW = (S > 1) ? $clog2(S) : 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    spi_txn_arbiter_if.master  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [1:0]    r_len;
    logic [SW-1:0] r_ss;
    logic [31:0]   r_tx;
    logic [31:0]   r_rx;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  r_done;
    logic [31:0]   r_rx_data;

    logic          r_cs, r_read, r_write;
    logic [4:0]    r_addr;
    logic [31:0]   r_wr_data;
    logic          w_read_nxt, w_write_nxt;
    logic [4:0]    w_addr_nxt;
    logic [31:0]   w_wr_data_nxt;

    logic [N-1:0]  w_pick;
    logic [PW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic          w_advance;
    logic          w_ready;
    logic [S-1:0]  w_sel_mask;
    logic          w_unused_rd;

    logic [1:0]    w_len_arr [N];
    logic [SW-1:0] w_ss_arr  [N];
    logic [31:0]   w_tx_arr  [N];
    logic [17:0]   w_cfg_arr [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_unpack
            assign w_len_arr[g] = bus.req_len[2*g +: 2];
            assign w_ss_arr[g]  = bus.req_ss[SW*g +: SW];
            assign w_tx_arr[g]  = bus.req_tx[32*g +: 32];
            assign w_cfg_arr[g] = bus.req_cfg[18*g +: 18];
        end
        // Active-low select; an out-of-range index matches no bit, so all ones
        for (genvar g = 0; g < S; g++) begin : g_sel
            assign w_sel_mask[g] = (r_ss != SW'(g));
        end
    endgenerate

    rr_arbiter #(.N(N)) u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     (bus.req),
        .i_advance (w_advance),
        .o_grant   (w_pick),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    assign w_advance   = (r_state == IDLE) && w_pick_valid;
    assign w_ready     = bus.m_rd_data[SPI_READY_BIT];
    assign w_unused_rd = ^bus.m_rd_data[31:9];

    // Next state and byte index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = CFG;
                    w_idx_nxt   = 2'd0;
                end
            end
            CFG:   w_state_nxt = SEL;
            SEL:   w_state_nxt = START;
            START: w_state_nxt = WAIT;
            WAIT:  w_state_nxt = POLL;
            POLL: begin
                if (w_ready) begin
                    if (r_idx == r_len) begin
                        w_state_nxt = DESEL;
                    end else begin
                        w_state_nxt = START;
                        w_idx_nxt   = r_idx + 2'd1;
                    end
                end
            end
            DESEL:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus outputs are registered, so they are decoded from the state being
    // entered. CFG is only entered from IDLE, before the request is latched,
    // hence the ctrl word comes straight from the winning requester.
    always_comb begin
        w_read_nxt    = 1'b0;
        w_write_nxt   = 1'b0;
        w_addr_nxt    = '0;
        w_wr_data_nxt = '0;
        case (w_state_nxt)
            CFG: begin
                w_write_nxt   = 1'b1;
                w_addr_nxt    = SPI_ADDR_CTRL;
                w_wr_data_nxt = {14'b0, w_cfg_arr[w_pick_idx]};
            end
            SEL: begin
                w_write_nxt             = 1'b1;
                w_addr_nxt              = SPI_ADDR_SS;
                w_wr_data_nxt[S-1:0]    = w_sel_mask;
            end
            START: begin
                w_write_nxt         = 1'b1;
                w_addr_nxt          = SPI_ADDR_DATA;
                w_wr_data_nxt[7:0]  = r_tx[{w_idx_nxt, 3'b000} +: 8];
            end
            POLL: begin
                w_read_nxt = 1'b1;
                w_addr_nxt = SPI_ADDR_STAT;
            end
            DESEL: begin
                w_write_nxt          = 1'b1;
                w_addr_nxt           = SPI_ADDR_SS;
                w_wr_data_nxt[S-1:0] = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_len     <= '0;
            r_ss      <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_grant   <= '0;
            r_done    <= '0;
            r_rx_data <= '0;
            r_cs      <= 1'b0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cs      <= w_read_nxt | w_write_nxt;
            r_read    <= w_read_nxt;
            r_write   <= w_write_nxt;
            r_addr    <= w_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= (w_state_nxt == DONE) ? r_grant : '0;
            if (w_state_nxt == DONE) begin
                r_rx_data <= r_rx;
            end
            if (w_advance) begin
                r_grant <= w_pick;
                r_len   <= w_len_arr[w_pick_idx];
                r_ss    <= w_ss_arr[w_pick_idx];
                r_tx    <= w_tx_arr[w_pick_idx];
                r_rx    <= '0;
            end else if (r_state == DONE) begin
                r_grant <= '0;
            end
            if ((r_state == POLL) && w_ready) begin
                r_rx[{r_idx, 3'b000} +: 8] <= bus.m_rd_data[7:0];
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.done      = r_done;
    assign bus.rx_data   = r_rx_data;
    assign bus.m_cs      = r_cs;
    assign bus.m_read    = r_read;
    assign bus.m_write   = r_write;
    assign bus.m_addr    = r_addr;
    assign bus.m_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_txn_arbiter
//  Description : Self-checking bench for spi_txn_arbiter with a behavioural
//                loopback spi_core slot model and a transaction-level
//                reference model (expected write list, rx value, winner order,
//                latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_arbiter;

    localparam int N  = 2;
    localparam int S  = 2;
    localparam int SW = 2;   // wide enough to express an out-of-range slave

    typedef logic [36:0] wr_t;   // {addr[4:0], data[31:0]}

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_txn_arbiter_if #(.N(N), .S(S), .SW(SW)) bus ();

    spi_txn_arbiter #(.N(N), .S(S), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- spi_core slot model (MOSI looped to MISO) ------------
    int             sc_T     = 0;
    bit             sc_stuck = 1'b0;
    int             sc_cnt   = 0;
    logic [7:0]     sc_byte;
    logic [S-1:0]   sc_ss_n;

    always @(posedge clk) begin
        if (reset) begin
            sc_cnt  <= 0;
            sc_byte <= '0;
            sc_ss_n <= '1;
        end else if (bus.m_write && bus.m_addr == 5'd2) begin
            sc_byte <= bus.m_wr_data[7:0];
            sc_cnt  <= sc_T + 1;
        end else begin
            if (bus.m_write && bus.m_addr == 5'd1) sc_ss_n <= bus.m_wr_data[S-1:0];
            if (sc_cnt > 0) sc_cnt <= sc_cnt - 1;
        end
    end
    assign bus.m_rd_data = {23'b0, (sc_cnt == 0) && !sc_stuck, sc_byte};

    // ---------------- bus monitor ------------------------------------------
    int          proto_viol   = 0;
    int          done_cnt     = 0;
    int          grant_cycles = 0;
    wr_t         wr_q[$];
    int          done_q[$];
    logic [31:0] rx_q[$];

    always @(negedge clk) begin
        if (bus.m_write) wr_q.push_back({bus.m_addr, bus.m_wr_data});
        if ((bus.m_write && bus.m_read) || (bus.m_cs !== (bus.m_write | bus.m_read)) ||
            ($countones(bus.grant) > 1) || ($countones(bus.done) > 1) ||
            ((bus.done & ~bus.grant) != '0))
            proto_viol <= proto_viol + 1;
        if (bus.grant != '0) grant_cycles <= grant_cycles + 1;
        if (bus.done != '0) begin
            done_cnt <= done_cnt + 1;
            for (int i = 0; i < N; i++) if (bus.done[i]) done_q.push_back(i);
            rx_q.push_back(bus.rx_data);
        end
    end

    // ---------------- reference model --------------------------------------
    function automatic int sel_value(input int ss);
        int all_ones = (1 << S) - 1;
        return (ss < S) ? (all_ones & ~(1 << ss)) : all_ones;
    endfunction

    function automatic logic [31:0] model_rx(input int len, input logic [31:0] tx);
        logic [63:0] m = (64'd1 << (8 * (len + 1))) - 64'd1;
        return tx & m[31:0];
    endfunction

    task automatic model_writes(input int len, input int ss, input logic [31:0] tx,
                                input logic [17:0] cfg, output wr_t q[$]);
        logic [31:0] t = tx;
        q = {};
        q.push_back({5'd3, 14'b0, cfg});
        q.push_back({5'd1, 32'(sel_value(ss))});
        for (int b = 0; b <= len; b++) q.push_back({5'd2, 24'b0, t[8*b +: 8]});
        q.push_back({5'd1, 32'((1 << S) - 1)});
    endtask

    // Number of differing entries between the observed and expected write
    // lists; slave-select writes are judged on their S select bits only.
    function automatic int wr_diffs(input wr_t exp[$]);
        int d = 0;
        if (wr_q.size() != exp.size()) return 1000 + wr_q.size();
        foreach (exp[i]) begin
            if (exp[i][36:32] == 5'd1) begin
                if (wr_q[i][36:32] != 5'd1 || wr_q[i][S-1:0] != exp[i][S-1:0]) d++;
            end else if (wr_q[i] != exp[i]) d++;
        end
        return d;
    endfunction

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_q   = {};
        done_q = {};
        rx_q   = {};
    endtask

    task automatic set_fields(input int r, input int len, input int ss,
                              input logic [31:0] tx, input logic [17:0] cfg);
        bus.req_len[2*r +: 2]   = 2'(len);
        bus.req_ss[SW*r +: SW]  = SW'(ss);
        bus.req_tx[32*r +: 32]  = tx;
        bus.req_cfg[18*r +: 18] = cfg;
    endtask

    task automatic do_txn(input int r, input int len, input int ss, input logic [31:0] tx,
                          input logic [17:0] cfg, input int T,
                          output int gcyc, output bit timed_out);
        int g0, d0;
        sc_T = T;
        clear_logs();
        g0 = grant_cycles;
        d0 = done_cnt;
        set_fields(r, len, ss, tx, cfg);
        bus.req[r] = 1'b1;
        timed_out = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (done_cnt > d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.req[r] = 1'b0;
        tick();
        tick();
        gcyc = grant_cycles - g0;
    endtask

    // ---------------- tests --------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.grant !== '0) begin n_errors++; $display("FAIL reset_grant: got %h want 0", bus.grant); end
        n_checks++;
        if (bus.done !== '0) begin n_errors++; $display("FAIL reset_done: got %h want 0", bus.done); end
        n_checks++;
        if (bus.rx_data !== 32'h0) begin n_errors++; $display("FAIL reset_rx: got %h want 0", bus.rx_data); end
        n_checks++;
        if ({bus.m_cs, bus.m_read, bus.m_write} !== 3'b000) begin
            n_errors++; $display("FAIL reset_strobes: got %b want 000", {bus.m_cs, bus.m_read, bus.m_write});
        end
        n_checks++;
        if ({bus.m_addr, bus.m_wr_data} !== 37'h0) begin
            n_errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.m_addr, bus.m_wr_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        wr_t exp[$];
        int  gcyc, d;
        bit  to;
        model_writes(0, 1, 32'hA5, 18'd4, exp);
        do_txn(0, 0, 1, 32'h0000_00A5, 18'd4, 3, gcyc, to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL single_timeout: no done within bound"); end
        d = wr_diffs(exp);
        n_checks++;
        if (d != 0) begin n_errors++; $display("FAIL single_writes: %0d wrong of %0d got, want %0d", d, wr_q.size(), exp.size()); end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] != 0) begin
            n_errors++; $display("FAIL single_done: got %0d pulses want 1 on requester 0", done_q.size());
        end
        n_checks++;
        if (rx_q.size() < 1 || rx_q[0] !== model_rx(0, 32'hA5)) begin
            n_errors++; $display("FAIL single_rx: got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 32'hx, model_rx(0, 32'hA5));
        end
        n_checks++;
        if (gcyc != 4 + 1 * (3 + 3)) begin n_errors++; $display("FAIL single_latency: got %0d want %0d", gcyc, 4 + 6); end
    endtask

    task automatic test_four_byte();
        wr_t exp[$];
        int  gcyc, d, n2;
        bit  to;
        logic [31:0] tx = 32'h1122_3344;
        model_writes(3, 0, tx, 18'h2_0010, exp);
        do_txn(1, 3, 0, tx, 18'h2_0010, 2, gcyc, to);
        n2 = 0;
        foreach (wr_q[i]) if (wr_q[i][36:32] == 5'd2) n2++;
        n_checks++;
        if (n2 != 4) begin n_errors++; $display("FAIL four_data_writes: got %0d want 4", n2); end
        d = wr_diffs(exp);
        n_checks++;
        if (d != 0 || to) begin n_errors++; $display("FAIL four_order: %0d wrong entries, timeout %0d, want 0/0", d, to); end
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== model_rx(3, tx)) begin
            n_errors++; $display("FAIL four_rx: got %h want %h", (rx_q.size() > 0) ? rx_q[0] : 32'hx, model_rx(3, tx));
        end
        n_checks++;
        if (gcyc != 4 + 4 * (3 + 2)) begin n_errors++; $display("FAIL four_latency: got %0d want %0d", gcyc, 24); end
    endtask

    task automatic test_bad_ss();
        int  gcyc;
        bit  to;
        do_txn(0, 0, 3, 32'h3C, 18'h1_0002, 1, gcyc, to);
        n_checks++;
        if (wr_q.size() < 2 || wr_q[1][36:32] != 5'd1 || wr_q[1][S-1:0] != 2'(sel_value(3))) begin
            n_errors++; $display("FAIL badss_sel: got %h want addr 1 data %h", (wr_q.size() > 1) ? wr_q[1] : 37'hx, sel_value(3));
        end
        n_checks++;
        if (to || done_q.size() != 1) begin n_errors++; $display("FAIL badss_done: got %0d pulses want 1", done_q.size()); end
    endtask

    task automatic test_mid_change();
        wr_t exp[$];
        int  d0, d;
        bit  to;
        logic [31:0] tx = 32'h0000_BEEF;
        sc_T = 5;
        clear_logs();
        model_writes(1, 0, tx, 18'd7, exp);
        d0 = done_cnt;
        set_fields(0, 1, 0, tx, 18'd7);
        bus.req[0] = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.m_read) begin to = 1'b0; break; end
        end
        bus.req[0] = 1'b0;
        set_fields(0, 3, 1, 32'hDEAD_0000, 18'd9);
        for (int k = 0; k < 500 && done_cnt == d0; k++) tick();
        repeat (4) tick();
        d = wr_diffs(exp);
        n_checks++;
        if (to || d != 0) begin n_errors++; $display("FAIL midchg_writes: %0d wrong entries, timeout %0d, want 0/0", d, to); end
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== model_rx(1, tx)) begin
            n_errors++; $display("FAIL midchg_rx: got %0d dones rx %h want 1 rx %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 32'hx, model_rx(1, tx));
        end
        n_checks++;
        if (bus.grant !== '0) begin n_errors++; $display("FAIL midchg_regrant: got %h want 0", bus.grant); end
    endtask

    task automatic test_contention();
        int  ptr, w, got, d0;
        bit  to;
        logic [31:0] txs [N];
        int          lens[N];
        txs[0] = 32'hCAFE_0001; lens[0] = 0;
        txs[1] = 32'h0BAD_F00D; lens[1] = 1;
        sc_T = 2;
        clear_logs();
        reset = 1'b1;
        for (int r = 0; r < N; r++) set_fields(r, lens[r], r, txs[r], 18'd3);
        bus.req = '1;
        tick();
        tick();
        reset = 1'b0;
        d0 = done_cnt;
        to = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            tick();
            if (done_cnt - d0 >= 4) begin
                bus.req = '0;
                to = 1'b0;
                break;
            end
        end
        bus.req = '0;
        repeat (3) tick();
        n_checks++;
        if (to || done_q.size() != 4) begin n_errors++; $display("FAIL cont_count: got %0d dones want 4", done_q.size()); end
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            w = ptr;                      // all requesters pending: winner is the pointer
            ptr = (w + 1) % N;
            got = (k < done_q.size()) ? done_q[k] : -1;
            n_checks++;
            if (got != w) begin n_errors++; $display("FAIL cont_winner%0d: got %0d want %0d", k, got, w); end
            n_checks++;
            if (k >= rx_q.size() || rx_q[k] !== model_rx(lens[w], txs[w])) begin
                n_errors++; $display("FAIL cont_rx%0d: got %h want %h", k, (k < rx_q.size()) ? rx_q[k] : 32'hx, model_rx(lens[w], txs[w]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int  gcyc;
        bit  to;
        sc_stuck = 1'b1;
        sc_T = 0;
        clear_logs();
        set_fields(0, 0, 0, 32'h5A, 18'd1);
        bus.req[0] = 1'b1;
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (bus.m_read) begin to = 1'b0; break; end
        end
        repeat (3) tick();
        n_checks++;
        if (to || sc_ss_n !== S'(sel_value(0))) begin
            n_errors++; $display("FAIL rstmid_selected: got ss_n %b timeout %0d want %b", sc_ss_n, to, S'(sel_value(0)));
        end
        reset = 1'b1;
        bus.req = '0;
        tick();
        n_checks++;
        if (bus.grant !== '0) begin n_errors++; $display("FAIL rstmid_grant: got %h want 0", bus.grant); end
        n_checks++;
        if ({bus.m_cs, bus.m_read, bus.m_write} !== 3'b000) begin
            n_errors++; $display("FAIL rstmid_bus: got %b want 000", {bus.m_cs, bus.m_read, bus.m_write});
        end
        n_checks++;
        if (sc_ss_n !== '1) begin n_errors++; $display("FAIL rstmid_ss_n: got %b want all ones", sc_ss_n); end
        reset = 1'b0;
        sc_stuck = 1'b0;
        tick();
        do_txn(1, 2, 1, 32'h00C0_FFEE, 18'd2, 1, gcyc, to);
        n_checks++;
        if (to || done_q.size() != 1 || done_q[0] != 1 || rx_q[0] !== model_rx(2, 32'h00C0_FFEE)) begin
            n_errors++; $display("FAIL rstmid_fresh: got %0d dones rx %h want 1 rx %h", done_q.size(),
                                 (rx_q.size() > 0) ? rx_q[0] : 32'hx, model_rx(2, 32'h00C0_FFEE));
        end
    endtask

    task automatic test_random();
        wr_t exp[$];
        int  r, len, ss, T, gcyc, d;
        bit  to;
        logic [31:0] tx;
        logic [17:0] cfg;
        for (int it = 0; it < 12; it++) begin
            r   = $urandom_range(N - 1, 0);
            len = $urandom_range(3, 0);
            ss  = $urandom_range(3, 0);
            T   = $urandom_range(4, 0);
            tx  = $urandom;
            cfg = 18'($urandom);
            model_writes(len, ss, tx, cfg, exp);
            do_txn(r, len, ss, tx, cfg, T, gcyc, to);
            d = wr_diffs(exp);
            n_checks++;
            if (to || d != 0) begin n_errors++; $display("FAIL rand%0d_writes: %0d wrong entries, timeout %0d, want 0/0", it, d, to); end
            n_checks++;
            if (done_q.size() != 1 || done_q[0] != r || rx_q[0] !== model_rx(len, tx)) begin
                n_errors++; $display("FAIL rand%0d_result: got %0d dones rx %h want 1 on %0d rx %h", it, done_q.size(),
                                     (rx_q.size() > 0) ? rx_q[0] : 32'hx, r, model_rx(len, tx));
            end
            n_checks++;
            if (gcyc != 4 + (len + 1) * (3 + T)) begin
                n_errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, gcyc, 4 + (len + 1) * (3 + T));
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (proto_viol != 0) begin n_errors++; $display("FAIL bus_protocol: got %0d violations want 0", proto_viol); end
    endtask

    initial begin
        bus.req     = '0;
        bus.req_len = '0;
        bus.req_ss  = '0;
        bus.req_tx  = '0;
        bus.req_cfg = '0;
        test_reset();
        test_single();
        test_four_byte();
        test_bad_ss();
        test_mid_change();
        test_contention();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_txn_arbiter.md
Name: spi_txn_arbiter

Overview:
- Shares one spi_core slot among N requesters; each requester issues a 1–4 byte SPI transaction with its own slave select and control word.
- Sequences the spi_core slot bus: config write, slave select assert, per-byte start/poll/capture, slave deselect.
- Sits between local masters (sensor pollers, flash reader) and the spi_core slot port; replaces direct processor access to that slot.

Parameters:
- N, 2, number of requesters (2..8).
- S, 2, spi_core slave-select width.
- SW, $clog2(S) (min 1), width of the slave index field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester transaction request; level.
- req_len  in  2N  bytes minus 1 per requester (0..3 → 1..4 bytes).
- req_ss  in  SW*N  slave index per requester.
- req_tx  in  32N  tx bytes; byte k = bits [8k+7:8k], byte 0 sent first.
- req_cfg  in  18N  spi_core control word: [15:0] dvsr, [16] cpol, [17] cpha.
- grant  out  N  one-hot; high for the whole transaction of the served requester.
- done  out  N  one-cycle pulse at completion.
- rx_data  out  32  received bytes, byte k in [8k+7:8k], unused bytes 0; valid in the done cycle, held until the next done.
- m_cs, m_read, m_write  out  1 each  slot strobes to spi_core.
- m_addr  out  5  slot register address: 1 = ss, 2 = data/start, 3 = ctrl.
- m_wr_data  out  32  slot write data.
- m_rd_data  in  32  slot read data: [8] ready, [7:0] last rx byte; combinational from spi_core.

Behaviour:
- Reset (synchronous): state IDLE, RR pointer 0, and all of grant, done, rx_data, m_cs, m_read, m_write, m_addr, m_wr_data cleared to 0.
- spi_core must share this reset. It resets its own ss_n to all-ones, so a reset mid-transaction leaves no slave selected.
- Bus outputs are registered. m_write and m_read are mutually exclusive. m_cs is high whenever either is high.
- IDLE:
  - When any req is high, select the first requester at or after the RR pointer, wrapping.
  - Latch its len, ss, tx and cfg into internal registers; set grant; go to CFG.
  - After a grant, the RR pointer becomes winner+1 mod N.
- CFG: one write cycle, addr 3, wr_data = {14'b0, cfg} → SEL.
- SEL: one write cycle, addr 1, wr_data[S-1:0] = ~(1 << ss).
  - If ss ≥ S, the value is all-ones: no slave selected, but the transfer still runs.
- START: one write cycle, addr 2, wr_data = {24'b0, tx byte[idx]} → WAIT.
- WAIT: bus idle for one cycle, to cover spi_core's one-cycle ready-drop latency → POLL.
- POLL:
  - Read cycles at addr 0, repeated every cycle while m_rd_data[8] = 0.
  - When [8] = 1, capture [7:0] into rx byte[idx] in the same cycle.
  - If idx == len → DESEL; otherwise idx+1 and go to START.
- DESEL: one write cycle, addr 1, wr_data = all-ones → DONE.
- DONE: pulse done[winner]; rx_data is valid; grant drops at the end of the cycle → IDLE.
- Latency for L bytes with spi_core byte time T cycles (ready low for T): total = 1 (IDLE grant) + 2 + L·(3 + T) + 2.
- Requester inputs are sampled only at grant. Changes or req deassertion during a transaction are ignored; the transaction always completes.
- A requester holding req after done is re-arbitrated normally. It cannot win back-to-back when another req is pending.
- Every transaction writes ctrl, even when it is unchanged, because cpol/cpha must settle before ss assertion.
- There is no poll timeout: a stuck ready = 0 holds POLL indefinitely.
- The rx byte register is cleared at grant.

Decomposition:
- Package spi_arb_pkg:
  - typedef state_t (IDLE, CFG, SEL, START, WAIT, POLL, DESEL, DONE).
  - Slot address constants SPI_ADDR_SS = 5'd1, SPI_ADDR_DATA = 5'd2, SPI_ADDR_CTRL = 5'd3.
  - Constant SPI_READY_BIT = 8.
- One sub-module, rr_arbiter: N-bit round-robin picker with a pointer; outputs a one-hot grant and a valid flag.

Test Plan:
- Single request (N=2): req[0], len 0, ss 1, tx 8'hA5, cfg dvsr 4. Expect writes in order:
  1. addr3 = 0x00004
  2. addr1 = 2'b01
  3. addr2 = 0xA5
  4. addr1 = 2'b11

  With the slave model looping MOSI→MISO: done[0] pulses once, rx_data = 0x000000A5.
- 4-byte request: tx 0x11223344, len 3. Expect the MOSI byte order 44, 33, 22, 11; rx_data = 0x11223344; exactly 4 addr2 writes.
- Contention: req[0] and req[1] both asserted continuously from reset. Expect grants alternating 0, 1, 0, 1, with no back-to-back wins.
- Out-of-range ss = 3 with S = 2. Expect the SEL write to be 2'b11 (no ss_n low) and the transaction still completes with a done pulse.
- Request changes mid-transaction: drop req and change req_tx during POLL. Expect no effect; the original tx is sent and done fires.
- Reset asserted during POLL. Next cycle: grant = 0, the bus is idle, spi_ss_n is all-ones. A fresh request then completes normally.
